// File: rtl/lcd_de_rx_pkg.sv
// Shared LCD timing constants and receiver FSM state encoding, common with the LCD driver.
// Pure definitions: no logic, no latency, no backpressure.
package lcd_de_rx_pkg;

   localparam int LCD_WIDTH  = 640;
   localparam int LCD_HEIGHT = 480;
   localparam int H_BLANKING = 160;
   localparam int V_BLANKING = 45;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VBLANK = 2'd1,
      LINE   = 2'd2,
      HBLANK = 2'd3
   } state_t;

endpackage

// File: rtl/lcd_de_meas.sv
// DE blank-run, run-length and line counters with saturation, plus width/height compare pulses.
// Error pulses appear one cycle after the line_end/frame_end strobe; no backpressure.
module lcd_de_meas
   import lcd_de_rx_pkg::*;
#(
   parameter int H_ACTIVE      = LCD_WIDTH,
   parameter int V_ACTIVE      = LCD_HEIGHT,
   parameter int VBLANK_DETECT = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        de,
   input  logic        line_start,
   input  logic        frame_start,
   input  logic        line_end,
   input  logic        frame_end,
   output logic        blank_hit,
   output logic [10:0] run_len,
   output logic [9:0]  line_cnt,
   output logic [10:0] meas_width,
   output logic [9:0]  meas_height,
   output logic        err_width,
   output logic        err_height
);

   localparam int BW = $clog2(VBLANK_DETECT + 1);
   localparam logic [BW-1:0] VD_B = BW'(VBLANK_DETECT);
   localparam logic [10:0]   H_W  = 11'(H_ACTIVE);
   localparam logic [9:0]    V_W  = 10'(V_ACTIVE);

   logic [BW-1:0] blank_cnt;

   assign blank_hit = (blank_cnt == VD_B);

   always_ff @(posedge clk) begin
      if (rst) begin
         blank_cnt   <= '0;
         run_len     <= '0;
         line_cnt    <= '0;
         meas_width  <= '0;
         meas_height <= '0;
         err_width   <= 1'b0;
         err_height  <= 1'b0;
      end else begin
         if (de)
            blank_cnt <= '0;
         else if (!blank_hit)
            blank_cnt <= blank_cnt + BW'(1);

         // run_len is the count of pixels so far in the line, i.e. the x of the next pixel
         if (line_start)
            run_len <= 11'd1;
         else if (de && run_len != 11'h7ff)
            run_len <= run_len + 11'd1;

         if (frame_start)
            line_cnt <= 10'd1;
         else if (line_start && line_cnt != 10'h3ff)
            line_cnt <= line_cnt + 10'd1;

         err_width  <= 1'b0;
         err_height <= 1'b0;
         if (line_end) begin
            meas_width <= run_len;
            err_width  <= (run_len != H_W);
         end
         if (frame_end) begin
            meas_height <= line_cnt;
            err_height  <= (line_cnt != V_W);
         end
      end
   end

endmodule

// File: rtl/lcd_de_rx.sv
// DE-mode RGB receiver: recovers x/y, qualifies pixels, tracks lock from error-free frames.
// de_in -> pix_valid latency is 2 cycles; stream-only, no backpressure.
module lcd_de_rx
   import lcd_de_rx_pkg::*;
#(
   parameter int H_ACTIVE      = LCD_WIDTH,
   parameter int V_ACTIVE      = LCD_HEIGHT,
   parameter int VBLANK_DETECT = 1000,
   parameter int LOCK_FRAMES   = 2
) (
   input  logic        pixel_clk,
   input  logic        rst,
   input  logic        de_in,
   input  logic [7:0]  r_in,
   input  logic [7:0]  g_in,
   input  logic [7:0]  b_in,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        sof,
   output logic        eol,
   output logic        locked,
   output logic        err_width,
   output logic        err_height,
   output logic [10:0] meas_width,
   output logic [9:0]  meas_height
);

   localparam logic [10:0] H_W    = 11'(H_ACTIVE);
   localparam logic [9:0]  V_W    = 10'(V_ACTIVE);
   localparam logic [7:0]  LOCK_W = 8'(LOCK_FRAMES);

   logic        de_s0;
   logic [23:0] rgb_s0;
   state_t      state, state_nxt;
   logic        pixel, frame_start, line_start, line_end, frame_end;
   logic        blank_hit;
   logic [10:0] run_len;
   logic [9:0]  line_cnt;
   logic [10:0] cur_x;
   logic [9:0]  cur_y;
   logic        pix_ok;
   logic [7:0]  good_cnt;
   logic        frame_done, frame_bad;

   lcd_de_meas #(
      .H_ACTIVE      (H_ACTIVE),
      .V_ACTIVE      (V_ACTIVE),
      .VBLANK_DETECT (VBLANK_DETECT)
   ) u_meas (
      .clk         (pixel_clk),
      .rst         (rst),
      .de          (de_s0),
      .line_start  (line_start),
      .frame_start (frame_start),
      .line_end    (line_end),
      .frame_end   (frame_end),
      .blank_hit   (blank_hit),
      .run_len     (run_len),
      .line_cnt    (line_cnt),
      .meas_width  (meas_width),
      .meas_height (meas_height),
      .err_width   (err_width),
      .err_height  (err_height)
   );

   // A vblank decision and a DE rise can land on the same sample; the rise then opens the new frame.
   always_comb begin
      state_nxt   = state;
      pixel       = 1'b0;
      frame_start = 1'b0;
      line_start  = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;
      case (state)
         SEARCH: begin
            if (blank_hit) begin
               if (de_s0) begin
                  pixel       = 1'b1;
                  frame_start = 1'b1;
                  line_start  = 1'b1;
                  state_nxt   = LINE;
               end else begin
                  state_nxt = VBLANK;
               end
            end
         end
         VBLANK: begin
            if (de_s0) begin
               pixel       = 1'b1;
               frame_start = 1'b1;
               line_start  = 1'b1;
               state_nxt   = LINE;
            end
         end
         LINE: begin
            if (de_s0) begin
               pixel = 1'b1;
            end else begin
               line_end  = 1'b1;
               state_nxt = HBLANK;
            end
         end
         HBLANK: begin
            if (blank_hit) begin
               frame_end = 1'b1;
               if (de_s0) begin
                  pixel       = 1'b1;
                  frame_start = 1'b1;
                  line_start  = 1'b1;
                  state_nxt   = LINE;
               end else begin
                  state_nxt = VBLANK;
               end
            end else if (de_s0) begin
               pixel      = 1'b1;
               line_start = 1'b1;
               state_nxt  = LINE;
            end
         end
         default: state_nxt = SEARCH;
      endcase
   end

   assign cur_x  = line_start ? 11'd0 : run_len;
   assign cur_y  = frame_start ? 10'd0 : (line_start ? line_cnt : line_cnt - 10'd1);
   assign pix_ok = pixel && (cur_x < H_W) && (cur_y < V_W);

   always_ff @(posedge pixel_clk) begin
      if (rst) begin
         de_s0      <= 1'b0;
         rgb_s0     <= '0;
         state      <= SEARCH;
         pix_valid  <= 1'b0;
         pix_data   <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         sof        <= 1'b0;
         eol        <= 1'b0;
         locked     <= 1'b0;
         good_cnt   <= '0;
         frame_done <= 1'b0;
         frame_bad  <= 1'b0;
      end else begin
         de_s0     <= de_in;
         rgb_s0    <= {r_in, g_in, b_in};
         state     <= state_nxt;
         pix_valid <= pix_ok;
         sof       <= pix_ok && frame_start;
         eol       <= pix_ok && (cur_x == H_W - 11'd1);
         if (pix_ok) begin
            pix_data <= rgb_s0;
            pix_x    <= cur_x[9:0];
            pix_y    <= cur_y;
         end

         // frame_done lines up with err_height, so the height verdict is known when scoring the frame
         frame_done <= frame_end;
         if (frame_done)
            frame_bad <= 1'b0;
         else if (err_width)
            frame_bad <= 1'b1;

         if (err_width || err_height) begin
            good_cnt <= '0;
            locked   <= 1'b0;
         end else if (frame_done) begin
            if (frame_bad) begin
               good_cnt <= '0;
               locked   <= 1'b0;
            end else if (good_cnt != 8'hff) begin
               good_cnt <= good_cnt + 8'd1;
               locked   <= (good_cnt + 8'd1) >= LOCK_W;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_de_rx.sv
// Bench for lcd_de_rx with reduced timing: stimulus model pushes expected pixels to a scoreboard,
// a negedge monitor pops and checks them at exactly two cycles after the DE sample was driven.
module tb_lcd_de_rx;

   localparam int H   = 16;
   localparam int V   = 8;
   localparam int HB  = 6;
   localparam int VD  = 20;
   localparam int VBL = 30;

   logic        pixel_clk = 1'b0;
   logic        rst = 1'b1;
   logic        de_in = 1'b0;
   logic [7:0]  r_in = 8'h0, g_in = 8'h0, b_in = 8'h0;
   logic        pix_valid, sof, eol, locked, err_width, err_height;
   logic [23:0] pix_data;
   logic [9:0]  pix_x, pix_y, meas_height;
   logic [10:0] meas_width;

   lcd_de_rx #(
      .H_ACTIVE      (H),
      .V_ACTIVE      (V),
      .VBLANK_DETECT (VD),
      .LOCK_FRAMES   (2)
   ) dut (
      .pixel_clk   (pixel_clk),
      .rst         (rst),
      .de_in       (de_in),
      .r_in        (r_in),
      .g_in        (g_in),
      .b_in        (b_in),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .sof         (sof),
      .eol         (eol),
      .locked      (locked),
      .err_width   (err_width),
      .err_height  (err_height),
      .meas_width  (meas_width),
      .meas_height (meas_height)
   );

   always #5 pixel_clk = ~pixel_clk;

   int cyc = 0;
   always @(posedge pixel_clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic        sof;
      logic        eol;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] d;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int total = 0, bad = 0;
   int v_cnt = 0, sof_cnt = 0, eol_cnt = 0, ew_cnt = 0, eh_cnt = 0;

   // stimulus-side reference model of the receiver's frame/line tracking
   int m_low = 0, m_x = 0, m_y = 0;
   bit m_sync = 1'b0, m_prev = 1'b0;

   always @(negedge pixel_clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         total++;
         bad++;
         $display("FAIL missing_pixel x=%0d y=%0d due cycle %0d, still absent at cycle %0d",
                  sb[0].x, sb[0].y, sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (pix_valid) begin
         v_cnt++;
         if (sof) sof_cnt++;
         if (eol) eol_cnt++;
         total++;
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            bad++;
            $display("FAIL unexpected_pixel got x=%0d y=%0d at cycle %0d, required no pix_valid",
                     pix_x, pix_y, cyc);
         end else begin
            mon_e = sb.pop_front();
            if ({sof, eol, pix_x, pix_y, pix_data} !== {mon_e.sof, mon_e.eol, mon_e.x, mon_e.y, mon_e.d}) begin
               bad++;
               $display("FAIL pixel got sof=%b eol=%b x=%0d y=%0d d=%h, required sof=%b eol=%b x=%0d y=%0d d=%h",
                        sof, eol, pix_x, pix_y, pix_data, mon_e.sof, mon_e.eol, mon_e.x, mon_e.y, mon_e.d);
            end
         end
      end
      if (err_width) ew_cnt++;
      if (err_height) eh_cnt++;
   end

   task automatic drive(input logic de, input logic [23:0] rgb);
      exp_t e;
      @(posedge pixel_clk);
      #1;
      de_in = de;
      {r_in, g_in, b_in} = rgb;
      if (rst) begin
         m_sync = 1'b0;
         m_low  = 0;
      end else if (de) begin
         if (m_low >= VD) begin
            m_sync = 1'b1;
            m_x = 0;
            m_y = 0;
         end else if (!m_prev) begin
            m_x = 0;
            m_y++;
         end else begin
            m_x++;
         end
         if (m_sync && m_x < H && m_y < V) begin
            e.cyc = cyc + 2;
            e.sof = (m_x == 0 && m_y == 0);
            e.eol = (m_x == H - 1);
            e.x   = 10'(m_x);
            e.y   = 10'(m_y);
            e.d   = rgb;
            sb.push_back(e);
         end
         m_low = 0;
      end else if (m_low < VD) begin
         m_low++;
      end
      m_prev = de;
   endtask

   task automatic gen_line(input int l, input int len, input int gap);
      for (int x = 0; x < len; x++) drive(1'b1, {8'(x), 8'(l), 8'(x + 3 * l)});
      repeat (gap) drive(1'b0, 24'h0);
   endtask

   task automatic gen_frame(input int nlines, input int odd_line, input int odd_len,
                            input int gap_line, input int gap_len);
      for (int l = 0; l < nlines; l++)
         gen_line(l, (l == odd_line) ? odd_len : H,
                  (l == nlines - 1) ? VBL : ((l == gap_line) ? gap_len : HB));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) drive(1'b0, 24'h0);
      @(negedge pixel_clk);
      total++;
      if ({pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err_width, err_height,
           meas_width, meas_height} !== 80'h0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b x=%0d y=%0d locked=%b mw=%0d mh=%0d, required all 0",
                  pix_valid, pix_x, pix_y, locked, meas_width, meas_height);
      end
      rst = 1'b0;
      repeat (VBL) drive(1'b0, 24'h0);
   endtask

   task automatic test_nominal();
      int v0, s0, e0, w0, h0;
      for (int f = 1; f <= 3; f++) begin
         v0 = v_cnt; s0 = sof_cnt; e0 = eol_cnt; w0 = ew_cnt; h0 = eh_cnt;
         gen_frame(V, -1, 0, -1, 0);
         @(negedge pixel_clk);
         total++;
         if (v_cnt - v0 != H * V || sof_cnt - s0 != 1 || eol_cnt - e0 != V) begin
            bad++;
            $display("FAIL nominal_counts frame %0d got valid=%0d sof=%0d eol=%0d, required %0d/1/%0d",
                     f, v_cnt - v0, sof_cnt - s0, eol_cnt - e0, H * V, V);
         end
         total++;
         if (meas_width !== 11'(H) || meas_height !== 10'(V) || ew_cnt != w0 || eh_cnt != h0) begin
            bad++;
            $display("FAIL nominal_meas frame %0d got w=%0d h=%0d errw=%0d errh=%0d, required %0d/%0d/0/0",
                     f, meas_width, meas_height, ew_cnt - w0, eh_cnt - h0, H, V);
         end
         total++;
         if (locked !== (f >= 2)) begin
            bad++;
            $display("FAIL nominal_lock frame %0d got %b, required %b", f, locked, f >= 2);
         end
      end
   endtask

   task automatic test_long_line();
      int v0, w0, h0;
      v0 = v_cnt; w0 = ew_cnt; h0 = eh_cnt;
      gen_frame(V, V - 1, H + 1, -1, 0);
      @(negedge pixel_clk);
      total++;
      if (ew_cnt - w0 != 1 || eh_cnt != h0 || meas_width !== 11'(H + 1)) begin
         bad++;
         $display("FAIL long_line got errw=%0d errh=%0d w=%0d, required 1/0/%0d",
                  ew_cnt - w0, eh_cnt - h0, meas_width, H + 1);
      end
      total++;
      if (v_cnt - v0 != H * V || locked !== 1'b0) begin
         bad++;
         $display("FAIL long_line_valid got valid=%0d locked=%b, required %0d/0", v_cnt - v0, locked, H * V);
      end
      for (int f = 1; f <= 2; f++) begin
         gen_frame(V, -1, 0, -1, 0);
         @(negedge pixel_clk);
         total++;
         if (locked !== (f == 2)) begin
            bad++;
            $display("FAIL relock good frame %0d got %b, required %b", f, locked, f == 2);
         end
      end
   endtask

   task automatic test_height();
      int v0, w0, h0;
      v0 = v_cnt; w0 = ew_cnt; h0 = eh_cnt;
      gen_frame(V - 1, -1, 0, -1, 0);
      @(negedge pixel_clk);
      total++;
      if (eh_cnt - h0 != 1 || meas_height !== 10'(V - 1) || locked !== 1'b0 || v_cnt - v0 != H * (V - 1)) begin
         bad++;
         $display("FAIL short_frame got errh=%0d h=%0d locked=%b valid=%0d, required 1/%0d/0/%0d",
                  eh_cnt - h0, meas_height, locked, v_cnt - v0, V - 1, H * (V - 1));
      end
      v0 = v_cnt; h0 = eh_cnt;
      gen_frame(V + 1, -1, 0, -1, 0);
      @(negedge pixel_clk);
      total++;
      if (eh_cnt - h0 != 1 || meas_height !== 10'(V + 1) || v_cnt - v0 != H * V || ew_cnt != w0) begin
         bad++;
         $display("FAIL long_frame got errh=%0d h=%0d valid=%0d errw=%0d, required 1/%0d/%0d/0",
                  eh_cnt - h0, meas_height, v_cnt - v0, ew_cnt - w0, V + 1, H * V);
      end
   endtask

   task automatic test_reset_mid();
      int v0, s0, w0, h0;
      for (int l = 0; l < 3; l++) gen_line(l, H, HB);
      for (int x = 0; x < H / 2; x++) drive(1'b1, {8'(x), 8'(3), 8'(x + 9)});
      rst = 1'b1;
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      @(negedge pixel_clk);
      @(negedge pixel_clk);
      total++;
      if ({pix_valid, pix_data, pix_x, pix_y, sof, eol, locked, err_width, err_height,
           meas_width, meas_height} !== 80'h0) begin
         bad++;
         $display("FAIL midframe_reset got valid=%b x=%0d y=%0d mw=%0d mh=%0d, required all 0",
                  pix_valid, pix_x, pix_y, meas_width, meas_height);
      end
      drive(1'b0, 24'h0);
      drive(1'b0, 24'h0);
      rst = 1'b0;
      v0 = v_cnt; s0 = sof_cnt; w0 = ew_cnt; h0 = eh_cnt;
      for (int x = H / 2; x < H; x++) drive(1'b1, {8'(x), 8'(3), 8'(x + 9)});
      repeat (HB) drive(1'b0, 24'h0);
      for (int l = 4; l < V; l++) gen_line(l, H, (l == V - 1) ? VBL : HB);
      @(negedge pixel_clk);
      total++;
      if (v_cnt != v0 || ew_cnt != w0 || eh_cnt != h0) begin
         bad++;
         $display("FAIL after_reset_quiet got valid=%0d errw=%0d errh=%0d, required 0/0/0",
                  v_cnt - v0, ew_cnt - w0, eh_cnt - h0);
      end
      gen_frame(V, -1, 0, -1, 0);
      @(negedge pixel_clk);
      total++;
      if (v_cnt - v0 != H * V || sof_cnt - s0 != 1 || ew_cnt != w0 || eh_cnt != h0 ||
          meas_width !== 11'(H) || meas_height !== 10'(V)) begin
         bad++;
         $display("FAIL recapture got valid=%0d sof=%0d errw=%0d errh=%0d w=%0d h=%0d, required %0d/1/0/0/%0d/%0d",
                  v_cnt - v0, sof_cnt - s0, ew_cnt - w0, eh_cnt - h0, meas_width, meas_height, H * V, H, V);
      end
   endtask

   task automatic test_blank_len();
      int v0, s0, h0;
      v0 = v_cnt; s0 = sof_cnt; h0 = eh_cnt;
      gen_frame(V, -1, 0, 3, VD - 1);
      @(negedge pixel_clk);
      total++;
      if (v_cnt - v0 != H * V || sof_cnt - s0 != 1 || eh_cnt != h0 || meas_height !== 10'(V)) begin
         bad++;
         $display("FAIL gap_below_vblank got valid=%0d sof=%0d errh=%0d h=%0d, required %0d/1/0/%0d",
                  v_cnt - v0, sof_cnt - s0, eh_cnt - h0, meas_height, H * V, V);
      end
      v0 = v_cnt; s0 = sof_cnt; h0 = eh_cnt;
      gen_frame(V, -1, 0, 3, VD);
      @(negedge pixel_clk);
      total++;
      if (v_cnt - v0 != H * V || sof_cnt - s0 != 2 || eh_cnt - h0 != 2 || meas_height !== 10'(V - 4)) begin
         bad++;
         $display("FAIL gap_at_vblank got valid=%0d sof=%0d errh=%0d h=%0d, required %0d/2/2/%0d",
                  v_cnt - v0, sof_cnt - s0, eh_cnt - h0, meas_height, H * V, V - 4);
      end
   endtask

   task automatic test_ramp();
      logic [23:0] last_d;
      last_d = {8'(H - 1), 8'(V - 1), 8'(H - 1 + 3 * (V - 1))};
      gen_frame(V, -1, 0, -1, 0);
      @(negedge pixel_clk);
      total++;
      if (pix_data !== last_d || pix_x !== 10'(H - 1) || pix_y !== 10'(V - 1) || sb.size() != 0) begin
         bad++;
         $display("FAIL ramp_last got d=%h x=%0d y=%0d pending=%0d, required d=%h x=%0d y=%0d pending=0",
                  pix_data, pix_x, pix_y, sb.size(), last_d, H - 1, V - 1);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_long_line();
      test_height();
      test_reset_mid();
      test_blank_len();
      test_ramp();
      repeat (4) @(negedge pixel_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
